// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction-memory boot loader and core run sequencer
module imem_boot_ctrl #(
    parameter int          ADDR_W     = 19,
    parameter int          BASE_ADDR  = 1,
    parameter int unsigned RUN_CYCLES = 57
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_instr,
    input  logic              ld_last,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_grant,
    output logic              core_start,
    input  logic              core_halt,
    output logic              done,
    output logic              halt_cause,
    output logic              ld_err,
    output logic [ADDR_W-1:0] ld_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_PTR = '1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [31:0]       wdata_q;
    logic [31:0]       run_cnt;
    logic              wea_q;
    logic              cause_q;
    logic              err_q;
    logic              hs;

    // A word is accepted only while loading; ld_valid is ignored elsewhere.
    assign hs = (state == LOAD) && ld_valid;

    // Sequencer: load words into the i-cache, pulse START, run the core, park in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= BASE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            run_cnt <= '0;
            wea_q   <= 1'b0;
            cause_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wea_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_req) begin
                        state  <= LOAD;
                        wr_ptr <= BASE;
                        addr_q <= BASE;
                    end
                end
                LOAD: begin
                    addr_q <= wr_ptr;
                    if (hs) begin
                        wea_q   <= 1'b1;
                        wdata_q <= ld_instr;
                        wr_ptr  <= wr_ptr + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (ld_last) begin
                            state <= START;
                        end else if (wr_ptr == TOP_PTR) begin
                            // Address space exhausted before the program ended.
                            state   <= DONE;
                            err_q   <= 1'b1;
                            cause_q <= 1'b0;
                        end
                    end
                end
                START: begin
                    // Final write is visible this cycle; counter primed so RUN starts at 1.
                    wdata_q <= '0;
                    addr_q  <= '0;
                    run_cnt <= 32'd1;
                    state   <= RUN;
                end
                RUN: begin
                    if (core_halt || (run_cnt == RUN_CYCLES)) begin
                        state   <= DONE;
                        cause_q <= core_halt;
                    end else begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                end
                DONE: begin
                    wdata_q <= '0;
                    if (boot_req) begin
                        state   <= LOAD;
                        err_q   <= 1'b0;
                        count_q <= '0;
                        cause_q <= 1'b0;
                        wr_ptr  <= BASE;
                        addr_q  <= BASE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decode straight from state so reset clears them immediately.
    always_comb begin
        ld_ready   = (state == LOAD);
        f_grant    = (state == RUN);
        core_start = (state == RUN);
        done       = (state == DONE);
        halt_cause = cause_q;
        ld_err     = err_q;
        ld_count   = count_q;
        mem_wea    = wea_q;
        mem_addr   = (state == RUN) ? f_addr : addr_q;
        mem_wdata  = (state == RUN) ? 32'd0 : wdata_q;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

    localparam int          AW   = 19;
    localparam int          AW2  = 3;
    localparam int          BASE = 1;
    localparam int unsigned RC   = 57;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          boot_req = 0, ld_valid = 0, ld_last = 0, core_halt = 0;
    logic [31:0]   ld_instr = '0;
    logic [AW-1:0] f_addr = '0;
    logic          ld_ready, mem_wea, f_grant, core_start, done, halt_cause, ld_err;
    logic [AW-1:0] mem_addr, ld_count;
    logic [31:0]   mem_wdata;

    logic           boot_req_b = 0, ld_valid_b = 0, ld_last_b = 0, core_halt_b = 0;
    logic [31:0]    ld_instr_b = '0;
    logic [AW2-1:0] f_addr_b = '0;
    logic           ld_ready_b, mem_wea_b, f_grant_b, core_start_b, done_b, halt_cause_b, ld_err_b;
    logic [AW2-1:0] mem_addr_b, ld_count_b;
    logic [31:0]    mem_wdata_b;

    imem_boot_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .RUN_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .boot_req(boot_req), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_instr(ld_instr), .ld_last(ld_last),
        .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .f_addr(f_addr), .f_grant(f_grant), .core_start(core_start),
        .core_halt(core_halt), .done(done), .halt_cause(halt_cause),
        .ld_err(ld_err), .ld_count(ld_count)
    );

    imem_boot_ctrl #(.ADDR_W(AW2), .BASE_ADDR(BASE), .RUN_CYCLES(RC)) dut_small (
        .clk(clk), .rst_n(rst_n), .boot_req(boot_req_b), .ld_valid(ld_valid_b),
        .ld_ready(ld_ready_b), .ld_instr(ld_instr_b), .ld_last(ld_last_b),
        .mem_wea(mem_wea_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .f_addr(f_addr_b), .f_grant(f_grant_b), .core_start(core_start_b),
        .core_halt(core_halt_b), .done(done_b), .halt_cause(halt_cause_b),
        .ld_err(ld_err_b), .ld_count(ld_count_b)
    );

    logic [63:0] got_q[$], exp_q[$], got2_q[$], exp2_q[$];
    int run_cycles = 0, overlap_cnt = 0, start2_seen = 0;
    int checks = 0, passes = 0;

    // Observed i-cache writes and run-cycle accounting, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_wea) got_q.push_back({32'(mem_addr), mem_wdata});
        if (mem_wea_b) got2_q.push_back({32'(mem_addr_b), mem_wdata_b});
        if (core_start) run_cycles++;
        if (mem_wea && f_grant) overlap_cnt++;
        if (core_start_b) start2_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ctl"}, 64'({ld_ready, mem_wea, f_grant, core_start, done, halt_cause, ld_err}), 0);
        check({tag, " addr"}, 64'(mem_addr), 0);
        check({tag, " wdata"}, 64'(mem_wdata), 0);
        check({tag, " count"}, 64'(ld_count), 0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, " nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, " write"}, got_q[i], exp_q[i]);
    endtask

    task automatic boot();
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
    task automatic load(input int n, input int mode, input bit last, input bit poke, input bit rnd);
        int i = 0;
        int guard = 0;
        bit tog = 1'b0;
        logic v;
        logic [31:0] cur;
        cur = rnd ? $urandom : 32'hA0;
        while (i < n && guard < 2000) begin
            guard++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            ld_valid = v;
            ld_instr = cur;
            ld_last = last && (i == n - 1);
            boot_req = poke && (i == 1);
            if (v && ld_ready) begin
                exp_q.push_back({32'(BASE + i), cur});
                i++;
                cur = rnd ? $urandom : 32'hA0 + 32'(i);
            end
            step();
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        boot_req = 1'b0;
        check("load accepted", 64'(i), 64'(n));
    endtask

    // h = RUN cycle on which core_halt is raised (0 = never).
    task automatic run_case(input string tag, input int n, input int mode, input int h,
                            input bit poke, input bit rnd);
        int c;
        int exp_len;
        bit exp_cause;
        exp_q.delete();
        got_q.delete();
        run_cycles = 0;
        boot();
        check({tag, " done cleared"}, 64'({done, ld_err, halt_cause}), 0);
        check({tag, " count cleared"}, 64'(ld_count), 0);
        load(n, mode, 1'b1, poke, rnd);
        check({tag, " start write"}, 64'({mem_wea, core_start, ld_ready}), 64'(3'b100));
        step();
        check({tag, " run entry"}, 64'({core_start, f_grant, mem_wea}), 64'(3'b110));
        f_addr = AW'($urandom);
        #1;
        check({tag, " fetch addr"}, 64'(mem_addr), 64'(f_addr));
        check({tag, " run wdata"}, 64'(mem_wdata), 0);
        c = 1;
        while (!done && c < int'(RC) + 10) begin
            core_halt = (c == h);
            boot_req = poke && (c == 3);
            step();
            c++;
        end
        core_halt = 1'b0;
        boot_req = 1'b0;
        exp_cause = (h >= 1) && (h <= int'(RC));
        exp_len = exp_cause ? h : int'(RC);
        check({tag, " done"}, 64'({done, core_start, f_grant}), 64'(3'b100));
        check({tag, " halt_cause"}, 64'(halt_cause), 64'(exp_cause));
        check({tag, " run length"}, 64'(run_cycles), 64'(exp_len));
        check({tag, " ld_count"}, 64'(ld_count), 64'(n));
        compare_writes(tag);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        ld_valid = 1'b1;
        step();
        step();
        ld_valid = 1'b0;
        check("idle ignores valid", 64'({ld_ready, mem_wea}), 0);
        check("idle no writes", 64'(got_q.size()), 0);

        run_case("boot6", 6, 0, 0, 1'b0, 1'b0);
        run_case("halt10", 6, 0, 10, 1'b0, 1'b1);
        run_case("toggle", 5, 1, 0, 1'b0, 1'b1);
        run_case("halt_at_budget", 4, 0, int'(RC), 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            run_case("random", $urandom_range(1, 12), $urandom_range(0, 2),
                     $urandom_range(0, 62), 1'($urandom_range(0, 1)), 1'b1);

        // Reset while the third word is being offered.
        exp_q.delete();
        got_q.delete();
        boot();
        load(2, 0, 1'b0, 1'b0, 1'b1);
        ld_valid = 1'b1;
        ld_instr = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("mid-load reset");
        ld_valid = 1'b0;
        step();
        step();
        step();
        compare_writes("mid-load reset");
        rst_n = 1'b1;
        step();
        step();
        check("idle after reset", 64'(ld_ready), 0);
        run_case("after reset", 3, 0, 5, 1'b0, 1'b1);

        // Small address space: program longer than the space.
        boot_req_b = 1'b1;
        step();
        boot_req_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ld_valid_b = 1'b1;
            ld_instr_b = $urandom;
            if (BASE + k <= (1 << AW2) - 1) exp2_q.push_back({32'(BASE + k), ld_instr_b});
            step();
        end
        ld_valid_b = 1'b0;
        step();
        check("overflow nwrites", 64'(got2_q.size()), 64'(exp2_q.size()));
        for (int i = 0; i < exp2_q.size() && i < got2_q.size(); i++)
            check("overflow write", got2_q[i], exp2_q[i]);
        check("overflow flags", 64'({ld_err_b, done_b, halt_cause_b}), 64'(3'b110));
        check("overflow count", 64'(ld_count_b), 64'((1 << AW2) - BASE));
        check("overflow never started", 64'(start2_seen), 0);
        boot_req_b = 1'b1;
        step();
        boot_req_b = 1'b0;
        check("overflow restart", 64'({ld_err_b, done_b, ld_ready_b, ld_count_b}), 64'({3'b001, 3'b000}));

        check("no write while granted", 64'(overlap_cnt), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, instruction-memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 1, first load address.
REQ-003 SHALL have parameter RUN_CYCLES, default 57, run-cycle budget; valid range 1..2^32-1.
REQ-004 Ports SHALL be:
 clk  input  1  single clock, rising edge
 rst_n  input  1  asynchronous active-low reset
 boot_req  input  1  one-cycle pulse, begin load
 ld_valid  input  1  loader word valid
 ld_ready  output  1  controller accepts word
 ld_instr  input  32  instruction word
 ld_last  input  1  final word of program
 mem_wea  output  1  i-cache write enable
 mem_addr  output  ADDR_W  i-cache address
 mem_wdata  output  32  i-cache write data
 f_addr  input  ADDR_W  core fetch address
 f_grant  output  1  core fetch path owns i-cache
 core_start  output  1  core run enable, level
 core_halt  input  1  core-signalled halt
 done  output  1  run finished
 halt_cause  output  1  1 = core_halt, 0 = budget expiry
 ld_err  output  1  load overflowed address space
 ld_count  output  ADDR_W  words written in last load
REQ-005 Clock port SHALL be named clk and reset port rst_n; reset SHALL be asynchronous, active-low.

Function
REQ-006 FSM states SHALL be IDLE, LOAD, START, RUN, DONE.
REQ-007 IDLE: all outputs inactive; boot_req -> LOAD.
REQ-008 LOAD: ld_ready=1; handshake = ld_valid && ld_ready.
REQ-009 On each handshake, next cycle SHALL drive mem_wea=1, mem_wdata=ld_instr, mem_addr=write pointer (registered, one-cycle latency); write pointer starts at BASE_ADDR, increments by 1 per handshake; ld_count increments by 1.
REQ-010 Cycles without handshake in LOAD SHALL drive mem_wea=0, mem_addr=current write pointer.
REQ-011 Handshake with ld_last=1 SHALL move LOAD -> START; ld_ready=0 from START onward.
REQ-012 START: lasts exactly one cycle, carries final write (mem_wea=1); -> RUN.
REQ-013 RUN: core_start=1, f_grant=1, mem_wea=0, mem_addr=f_addr combinationally, mem_wdata=0.
REQ-014 RUN SHALL count cycles from 1 at first RUN cycle; count==RUN_CYCLES or core_halt=1 -> DONE.
REQ-015 core_halt and budget expiry in same cycle: halt_cause=1.
REQ-016 DONE: done=1, core_start=0, f_grant=0, halt_cause held; boot_req -> LOAD, clearing done, ld_err, ld_count, halt_cause, write pointer=BASE_ADDR.
REQ-017 Handshake writing address 2^ADDR_W-1 with ld_last=0: write SHALL complete, ld_err=1 next cycle, state -> DONE with halt_cause=0, core never started.
REQ-018 boot_req SHALL be ignored in LOAD, START, RUN; ld_valid SHALL be ignored outside LOAD.
REQ-019 mem_wea SHALL never be 1 while f_grant=1.
REQ-020 Cycle counter SHALL be 32 bits, never wrap (state leaves RUN at RUN_CYCLES).

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE and clear all outputs: ld_ready, mem_wea, mem_addr, mem_wdata, f_grant, core_start, done, halt_cause, ld_err, ld_count all 0.
REQ-022 Reset mid-LOAD or mid-RUN SHALL abort with no further mem writes; after release, boot_req required to restart.

Verification
REQ-023 boot_req; 6 words 0xA0..0xA5, last on 6th -> writes at addr 1..6 in order, ld_count=6, core_start rises cycle after START, done=1 after exactly 57 RUN cycles, halt_cause=0.
REQ-024 Same load, core_halt=1 at RUN cycle 10 -> done next cycle, halt_cause=1, core_start=0.
REQ-025 ld_valid toggled every other cycle during LOAD -> only handshake cycles write; addresses contiguous from 1.
REQ-026 ADDR_W=3, BASE_ADDR=1, 8 words no last -> writes 1..7, ld_err=1, DONE, core_start never 1.
REQ-027 rst_n low during 3rd load word -> all outputs 0 asynchronously, no mem_wea after; boot_req after release reloads from addr 1.
REQ-028 core_halt and count==RUN_CYCLES same cycle -> halt_cause=1; boot_req in RUN ignored; boot_req in DONE restarts LOAD with done=0.
